wave_ram_seq: RTL

//  Parametrised wave-pattern RAM with built-in playback sequencer for the APU wave channel.

---
 rtl/wave_ram_seq.sv | 78 +++++++
 1 files changed

// File: rtl/wave_ram_seq.sv
// wave_ram_seq: wave-pattern RAM with a period-timed playback sequencer.
// Gives CPU access while playing, with DMG (fetch-window only) or CGB (always) access rules.
module wave_ram_seq #(
   parameter int ADDR_W   = 4,
   parameter int SAMPLE_W = 4,
   parameter int PERIOD_W = 11,
   parameter int CGB_MODE = 0,
   localparam int SPB     = 8 / SAMPLE_W,
   localparam int LS      = $clog2(SPB),
   localparam int POS_W   = ADDR_W + LS
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                ce,
   input  logic                trig,
   input  logic                stop,
   input  logic [PERIOD_W-1:0] period,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [7:0]          cpu_wdata,
   input  logic                cpu_we,
   input  logic                cpu_re,
   output logic [7:0]          cpu_rdata,
   output logic                active,
   output logic [POS_W-1:0]    pos,
   output logic [SAMPLE_W-1:0] sample,
   output logic                fetch
);
   logic [7:0]          mem [2**ADDR_W];
   logic [7:0]          buffer;
   logic [PERIOD_W-1:0] timer;
   logic [POS_W-1:0]    pos_nx, sel;
   logic [ADDR_W-1:0]   cpu_byte, nx_byte;
   logic                tick, access_ok, boundary;

   assign tick      = ce & active;
   assign pos_nx    = pos + 1'b1;
   assign nx_byte   = ADDR_W'(pos_nx >> LS);
   assign boundary  = (pos_nx & POS_W'(SPB - 1)) == '0;
   // While playing, the CPU only ever sees the byte the sequencer is on.
   assign cpu_byte  = active ? ADDR_W'(pos >> LS) : cpu_addr;
   assign access_ok = !active || (CGB_MODE != 0) || fetch;
   assign sel       = pos & POS_W'(SPB - 1);
   assign sample    = SAMPLE_W'(buffer >> (SAMPLE_W * (SPB - 1 - int'(sel))));

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         active    <= 1'b0;
         pos       <= '0;
         timer     <= '0;
         buffer    <= '0;
         fetch     <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         fetch <= 1'b0;
         if (trig) begin
            active <= 1'b1;
            pos    <= '0;
            timer  <= period;
         end else if (stop) begin
            active <= 1'b0;
         end else if (tick) begin
            if (&timer) begin
               timer  <= period;
               pos    <= pos_nx;
               buffer <= mem[nx_byte];
               fetch  <= boundary;
            end else begin
               timer <= timer + 1'b1;
            end
         end
         if (cpu_re) cpu_rdata <= access_ok ? mem[cpu_byte] : 8'hFF;
      end
   end

   always_ff @(posedge clk) begin
      if (cpu_we && access_ok) mem[cpu_byte] <= cpu_wdata;
   end
endmodule
